// File: rtl/switch_reader_pkg.sv
// Shared types and mode codes for the switch reader and its per-bit debouncer.
package switch_reader_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } db_state_e;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_ALL   = 2'b11;

  // The LED shifter only steps in the two single-direction modes.
  function automatic logic is_shift_mode(input logic [1:0] mode);
    return (mode == MODE_LEFT) || (mode == MODE_RIGHT);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer followed by a STABLE/CHANGING debounce FSM.
module debounce_bit
  import switch_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic flip_c
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  db_state_e     state;
  db_state_e     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          clean_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      clean <= clean_nxt;
    end
  end

  // Accept a new level only after an unbroken run of differing samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clean_nxt = clean;
    flip_c    = 1'b0;
    case (state)
      STABLE: begin
        if (sync2 != clean) begin
          state_nxt = CHANGING;
          cnt_nxt   = CW'(1);
        end
      end
      CHANGING: begin
        if (sync2 == clean) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
          clean_nxt = ~clean;
          flip_c    = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/switch_reader.sv
// Debounced 2-bit mode switch with change pulse and LED-shifter step tick.
module switch_reader
  import switch_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw_raw,
  output logic [1:0] sw_clean,
  output logic       sw_changed,
  output logic       step_tick
);

  localparam int unsigned TW = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [1:0]    flip_c;
  logic          chg_c;
  logic [TW-1:0] tick_cnt;

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit0 (
    .clk    (clk),
    .rst    (rst),
    .raw    (sw_raw[0]),
    .clean  (sw_clean[0]),
    .flip_c (flip_c[0])
  );

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit1 (
    .clk    (clk),
    .rst    (rst),
    .raw    (sw_raw[1]),
    .clean  (sw_clean[1]),
    .flip_c (flip_c[1])
  );

  // Both bits flipping on one edge still yields a single pulse.
  assign chg_c = |flip_c;

  // The counter clears on the edge that raises sw_changed, so it reads 0 in
  // the pulse cycle and the first tick lands TICK_CYCLES cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_changed <= 1'b0;
      step_tick  <= 1'b0;
      tick_cnt   <= '0;
    end else begin
      sw_changed <= chg_c;
      if (chg_c || !is_shift_mode(sw_clean)) begin
        tick_cnt  <= '0;
        step_tick <= 1'b0;
      end else if (tick_cnt == TICK_LAST) begin
        tick_cnt  <= '0;
        step_tick <= 1'b1;
      end else begin
        tick_cnt  <= tick_cnt + TW'(1);
        step_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_reader.sv
// Directed vector table, hand sequences and random stimulus against a run-length model.
module tb_switch_reader;

  localparam int unsigned D = 4;
  localparam int unsigned T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw_raw = 2'b00;
  logic [1:0] sw_clean;
  logic       sw_changed;
  logic       step_tick;

  switch_reader #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_changed (sw_changed),
    .step_tick  (step_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: raw seen two edges late; a bit flips after D consecutive samples
  // differing from its clean value; ticks fall every T cycles after a change.
  logic [1:0] m_clean = 2'b00;
  logic [1:0] m_d1 = 2'b00;
  logic [1:0] m_d2 = 2'b00;
  logic       m_changed = 1'b0;
  logic       m_tick = 1'b0;
  int         run [2] = '{0, 0};
  int         age = 0;

  typedef struct {
    logic       rst;
    logic [1:0] raw;
    int         n;
    logic [1:0] clean;
    logic       changed;
    logic       tick;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [1:0] v);
    logic [1:0] prev;
    if (r) begin
      m_clean = 2'b00; m_d1 = 2'b00; m_d2 = 2'b00;
      m_changed = 1'b0; m_tick = 1'b0;
      run[0] = 0; run[1] = 0; age = 0;
    end else begin
      prev = m_clean;
      for (int b = 0; b < 2; b++) begin
        if (m_d2[b] != m_clean[b]) run[b]++;
        else run[b] = 0;
        if (run[b] == int'(D)) begin
          m_clean[b] = ~m_clean[b];
          run[b] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = v;
      m_changed = (m_clean != prev);
      if (m_changed) age = 0;
      else age++;
      m_tick = ((m_clean == 2'b01) || (m_clean == 2'b10)) && (age > 0) && ((age % int'(T)) == 0);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] v);
    rst = r;
    sw_raw = v;
    @(posedge clk);
    model_edge(r, v);
    #1;
    chk("model_clean", int'(sw_clean), int'(m_clean));
    chk("model_changed", int'(sw_changed), int'(m_changed));
    chk("model_tick", int'(step_tick), int'(m_tick));
  endtask

  initial begin
    int pulses;
    int ticks;
    int first;
    logic       r;
    logic [1:0] v;

    //            rst   raw    n  clean changed tick
    tbl.push_back('{1'b1, 2'b00, 2, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 5, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 7, 2'b01, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 2'b01, 7, 2'b01, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 2'b11, 5, 2'b01, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 1, 2'b11, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 10, 2'b11, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 6, 2'b00, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 10, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 5, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 1, 2'b11, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 6, 2'b00, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 4, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 1, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 5, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 1, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 3, 2'b00, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rst, tbl[i].raw);
      chk($sformatf("vec%0d_clean", i), int'(sw_clean), int'(tbl[i].clean));
      chk($sformatf("vec%0d_changed", i), int'(sw_changed), int'(tbl[i].changed));
      chk($sformatf("vec%0d_tick", i), int'(step_tick), int'(tbl[i].tick));
    end

    // Bounce on bit 0, then settle high.
    pulses = 0;
    step(1'b0, 2'b01); pulses += int'(sw_changed);
    step(1'b0, 2'b00); pulses += int'(sw_changed);
    step(1'b0, 2'b01); pulses += int'(sw_changed);
    step(1'b0, 2'b00); pulses += int'(sw_changed);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 2'b01);
      pulses += int'(sw_changed);
      if (i == 5) chk("bounce_early_clean", int'(sw_clean), 0);
    end
    chk("bounce_settle_clean", int'(sw_clean), 1);
    chk("bounce_settle_changed", int'(sw_changed), 1);

    // Mode 01 held for 40 cycles after the change pulse.
    ticks = 0;
    first = 0;
    for (int j = 1; j <= 40; j++) begin
      step(1'b0, 2'b01);
      pulses += int'(sw_changed);
      if (step_tick) begin
        ticks++;
        if (first == 0) first = j;
      end
    end
    chk("bounce_pulses", pulses, 1);
    chk("tick_count_40", ticks, 5);
    chk("tick_first_pos", first, int'(T));

    // 01 -> 11 -> 00: no ticks, one change pulse per transition.
    ticks = 0;
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 2'b11);
      ticks += int'(step_tick);
      pulses += int'(sw_changed);
    end
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 2'b00);
      ticks += int'(step_tick);
      pulses += int'(sw_changed);
    end
    chk("static_mode_ticks", ticks, 0);
    chk("static_mode_pulses", pulses, 2);

    // Random stimulus with held levels, bursts of bounce and rare resets.
    v = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) v = 2'($urandom_range(0, 3));
      step(r, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_reader.md
SWITCH_READER -- requirements
Module: switch_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable synchronized samples needed to accept a new switch level (minimum 2).
REQ-002 SHALL have parameter TICK_CYCLES, default 8, meaning the period in clk cycles of step_tick while a shift mode is active (minimum 2).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sw_raw  input  2  asynchronous, bouncing board switches.
REQ-006 sw_clean  output  2  debounced switch value, registered; the mode code consumed by the LED shifter.
REQ-007 sw_changed  output  1  one-cycle pulse in the cycle sw_clean takes a new value.
REQ-008 step_tick  output  1  one-cycle pulse; LED shifter step enable.

Function
REQ-009 Each sw_raw bit SHALL pass through a dedicated 2-flop synchronizer before any other logic.
REQ-010 Each bit SHALL run an independent FSM with two states: STABLE and CHANGING.
REQ-011 STABLE -> CHANGING SHALL occur when the synchronized bit differs from its sw_clean bit; on this transition the counter loads 1.
REQ-012 In CHANGING with the bit still differing, the counter SHALL increment once per cycle.
REQ-013 In CHANGING, when the counter equals DEBOUNCE_CYCLES-1 and the bit still differs, the FSM SHALL flip the sw_clean bit, clear the counter and return to STABLE.
REQ-014 In CHANGING, if the bit equals sw_clean again (a bounce), the FSM SHALL return to STABLE, clear the counter and leave sw_clean unchanged.
REQ-015 Latency: a sw_raw level held constant SHALL appear on sw_clean exactly 2+DEBOUNCE_CYCLES clock edges after the first edge that samples it.
REQ-016 The counter width SHALL be clog2(DEBOUNCE_CYCLES); the counter SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-017 sw_changed SHALL be high for exactly one cycle, registered, in the cycle sw_clean first shows a new value. When both bits update on the same edge, it SHALL produce a single pulse.
REQ-018 The tick counter SHALL run only while sw_clean is 2'b01 or 2'b10. It SHALL be held at 0 for 2'b00 and 2'b11, and step_tick SHALL stay 0 in those modes.
REQ-019 In modes 01 and 10, step_tick SHALL pulse when the tick counter equals TICK_CYCLES-1. The counter then wraps to 0, so the pulse period is TICK_CYCLES cycles.
REQ-020 Any cycle with sw_changed high SHALL clear the tick counter, so that the first tick after a mode change arrives TICK_CYCLES cycles later.
REQ-021 On simultaneous wrap and sw_changed, the clear SHALL win and step_tick SHALL be 0 in that cycle.

Reset
REQ-022 While rst is high at a clock edge, the following SHALL be cleared: synchronizer flops, sw_clean = 2'b00, sw_changed = 0, step_tick = 0, all FSMs = STABLE, all counters = 0.
REQ-023 Reset asserted mid-debounce or mid-tick SHALL abort the operation, with no pulse emitted on the release cycle.
REQ-024 After reset release, a sw_raw value of 2'b00 SHALL produce no sw_changed pulse. A nonzero value SHALL be debounced per REQ-015 and then pulse sw_changed.

Structure
REQ-025 A shared package SHALL hold the FSM state enum (STABLE, CHANGING) and the mode constants MODE_OFF = 00, MODE_LEFT = 01, MODE_RIGHT = 10 and MODE_ALL = 11.
REQ-026 The synchronizer, FSM and counter for one bit SHALL be a sub-module debounce_bit, instantiated twice. The tick generator and sw_changed logic SHALL stay in switch_reader.

Verification
REQ-027 With DEBOUNCE_CYCLES = 4, TICK_CYCLES = 8: reset, then sw_raw 00 -> 01 held -> sw_clean = 01 and one sw_changed pulse, both exactly 6 edges after the change.
REQ-028 Bounce: sw_raw[0] toggles 1,0,1,0 on successive cycles, then settles at 1 -> sw_clean changes only 6 edges after the final settle, with exactly one sw_changed pulse.
REQ-029 Ticks: sw_clean = 01 held for 40 cycles -> 5 step_tick pulses, the first 8 cycles after sw_changed and then every 8 cycles.
REQ-030 Mode 01 -> 11 -> 00 -> step_tick stays 0 throughout 11 and 00; sw_changed pulses once per transition.
REQ-031 Reset mid-debounce: rst asserted 2 cycles into CHANGING -> sw_clean = 00 with no pulse. After release with sw_raw still 01, sw_clean = 01 after 6 further edges.
REQ-032 Both bits 00 -> 11 on the same cycle -> sw_clean jumps to 11 in one edge with a single sw_changed pulse and no step_tick.
